// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding sram-like fetch port, instruction buffer toward decode.
// Optional macro IF_PREFETCH_BUF_EN selects a 2-entry prefetch FIFO instead of a single holding register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  // state  | meaning
  // S_REQ  | no request outstanding; may issue when a buffer slot is free
  // S_WAIT | one request outstanding; its data will be pushed
  // S_DROP | one request outstanding; its data is discarded (redirected)
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

`ifdef IF_PREFETCH_BUF_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] issued_pc;
  logic [1:0]  count;
  logic [1:0]  occupied;
  logic        handshake;
  logic        pop;
  logic        push;

  assign fs_to_ds_valid = (count != 2'd0);
  assign pop            = fs_to_ds_valid && ds_allowin;
  // A slot being popped this cycle counts as free, so the next fetch can issue in the pop cycle.
  assign occupied       = count - {1'b0, pop};
  assign inst_req       = !reset && (state == S_REQ) && (occupied < DEPTH);
  assign handshake      = inst_req && inst_addr_ok;
  assign push           = inst_data_ok && (state == S_WAIT) && !redirect;

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_addr  = pc;
  assign inst_wdata = 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      issued_pc <= 32'd0;
    end else begin
      if (redirect)       pc <= redirect_pc;
      else if (handshake) pc <= pc + 32'd4;
      if (handshake) issued_pc <= pc;
      case (state)
        S_REQ: begin
          if (handshake) state <= redirect ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (inst_data_ok)  state <= S_REQ;
          else if (redirect) state <= S_DROP;
        end
        S_DROP: begin
          if (inst_data_ok) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef IF_PREFETCH_BUF_EN
  logic [31:0] q0_pc, q0_inst, q1_pc, q1_inst;

  assign fs_pc   = q0_pc;
  assign fs_inst = q0_inst;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 2'd0;
      q0_pc   <= 32'd0;
      q0_inst <= 32'd0;
      q1_pc   <= 32'd0;
      q1_inst <= 32'd0;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            q0_pc   <= issued_pc;
            q0_inst <= inst_rdata;
          end else begin
            q1_pc   <= issued_pc;
            q1_inst <= inst_rdata;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          q0_pc   <= q1_pc;
          q0_inst <= q1_inst;
          count   <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q0_pc   <= issued_pc;
            q0_inst <= inst_rdata;
          end else begin
            q0_pc   <= q1_pc;
            q0_inst <= q1_inst;
            q1_pc   <= issued_pc;
            q1_inst <= inst_rdata;
          end
        end
        default: count <= count;
      endcase
    end
  end
`else
  logic [31:0] hold_pc, hold_inst;

  assign fs_pc   = hold_pc;
  assign fs_inst = hold_inst;

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      hold_pc   <= 32'd0;
      hold_inst <= 32'd0;
    end else if (redirect) begin
      count <= 2'd0;
    end else if (push) begin
      hold_pc   <= issued_pc;
      hold_inst <= inst_rdata;
      count     <= 2'd1;
    end else if (pop) begin
      count <= 2'd0;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector table, multi-cycle redirect/stall sequences and a randomized bridge/decode run for if_fetch_stage.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          aw;
    int          dw;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Waits for inst_req, holds addr_ok low aw cycles, handshakes, returns data dw cycles later.
  task automatic fetch(input int aw, input int dw, input logic [31:0] rd,
                       output logic [31:0] addr, output logic pre_valid);
    int n;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    settle();
    n = 0;
    while (!inst_req && n < 50) begin
      tick();
      settle();
      n++;
    end
    if (!inst_req) check("req_timeout", {31'd0, inst_req}, 32'd1);
    repeat (aw) tick();
    inst_addr_ok = 1'b1;
    settle();
    addr = inst_addr;
    tick();
    inst_addr_ok = 1'b0;
    repeat (dw - 1) tick();
    settle();
    pre_valid = fs_to_ds_valid;
    inst_data_ok = 1'b1;
    inst_rdata   = rd;
    tick();
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    settle();
  endtask

  initial begin
    vec_t        vecs [5];
    logic [31:0] a;
    logic        pv;
    logic [31:0] npc;
    logic [31:0] exp_pc;
    logic [31:0] paddr;
    int          acnt, dcnt, accepted, cyc;
    logic        busy;

    vecs[0] = '{0, 2, 32'h0280_0000, 32'h1c00_0000};
    vecs[1] = '{0, 1, 32'h1234_5678, 32'h1c00_0004};
    vecs[2] = '{3, 4, 32'hdead_beef, 32'h1c00_0008};
    vecs[3] = '{1, 7, 32'h0000_0001, 32'h1c00_000c};
    vecs[4] = '{5, 1, 32'hffff_ffff, 32'h1c00_0010};

    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; ds_allowin = 1'b1;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
    repeat (3) tick();
    settle();
    check("rst_req", {31'd0, inst_req}, 32'd0);
    check("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    reset = 1'b0;
    settle();
    check("rel_req", {31'd0, inst_req}, 32'd1);
    check("rel_addr", inst_addr, 32'h1c00_0000);
    check("const_wr", {31'd0, inst_wr}, 32'd0);
    check("const_size", {30'd0, inst_size}, 32'd2);
    check("const_wdata", inst_wdata, 32'd0);

    for (int i = 0; i < 5; i++) begin
      fetch(vecs[i].aw, vecs[i].dw, vecs[i].rdata, a, pv);
      check("vec_addr", a, vecs[i].exp_addr);
      check("vec_pre_valid", {31'd0, pv}, 32'd0);
      check("vec_valid", {31'd0, fs_to_ds_valid}, 32'd1);
      check("vec_pc", fs_pc, vecs[i].exp_addr);
      check("vec_inst", fs_inst, vecs[i].rdata);
      check("vec_next_req", {31'd0, inst_req}, 32'd1);
      check("vec_next_addr", inst_addr, vecs[i].exp_addr + 32'd4);
    end
    tick();

    // Decode stalls with one instruction held.
    ds_allowin = 1'b0;
    fetch(0, 1, 32'h1111_0014, a, pv);
    check("stall_addr", a, 32'h1c00_0014);
    check("stall_valid", {31'd0, fs_to_ds_valid}, 32'd1);
`ifdef IF_PREFETCH_BUF_EN
    check("pf_req", {31'd0, inst_req}, 32'd1);
    check("pf_addr", inst_addr, 32'h1c00_0018);
    fetch(0, 1, 32'h1111_0018, a, pv);
    check("pf_fetch_addr", a, 32'h1c00_0018);
`endif
    for (int k = 0; k < 5; k++) begin
      check("stall_hold_valid", {31'd0, fs_to_ds_valid}, 32'd1);
      check("stall_hold_pc", fs_pc, 32'h1c00_0014);
      check("stall_hold_inst", fs_inst, 32'h1111_0014);
      check("stall_no_req", {31'd0, inst_req}, 32'd0);
      tick();
      settle();
    end
    ds_allowin = 1'b1;
    settle();
`ifdef IF_PREFETCH_BUF_EN
    tick();
    settle();
    check("pf_head_pc", fs_pc, 32'h1c00_0018);
    check("pf_head_inst", fs_inst, 32'h1111_0018);
    check("pf_pop_req", {31'd0, inst_req}, 32'd1);
    check("pf_pop_addr", inst_addr, 32'h1c00_001c);
    npc = 32'h1c00_001c;
`else
    check("unstall_req", {31'd0, inst_req}, 32'd1);
    check("unstall_addr", inst_addr, 32'h1c00_0018);
    npc = 32'h1c00_0018;
`endif
    tick();

    // Redirect while a request is outstanding: its data is dropped.
    inst_addr_ok = 1'b1;
    settle();
    check("rd1_addr", inst_addr, npc);
    tick();
    inst_addr_ok = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h1c00_0100;
    tick();
    redirect = 1'b0;
    settle();
    check("rd1_req_low", {31'd0, inst_req}, 32'd0);
    inst_data_ok = 1'b1; inst_rdata = 32'hbad0_0001;
    tick();
    inst_data_ok = 1'b0;
    settle();
    check("rd1_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    check("rd1_req", {31'd0, inst_req}, 32'd1);
    check("rd1_new_addr", inst_addr, 32'h1c00_0100);
    fetch(0, 2, 32'h2222_0100, a, pv);
    check("rd1_fetch_addr", a, 32'h1c00_0100);
    check("rd1_fetch_valid", {31'd0, fs_to_ds_valid}, 32'd1);
    check("rd1_fetch_pc", fs_pc, 32'h1c00_0100);
    check("rd1_fetch_inst", fs_inst, 32'h2222_0100);

    // Redirect coinciding with data_ok: data discarded, no drop.
    inst_addr_ok = 1'b1;
    settle();
    check("rd2_addr", inst_addr, 32'h1c00_0104);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hbad0_0002;
    redirect = 1'b1; redirect_pc = 32'h1c00_0200;
    tick();
    inst_data_ok = 1'b0; redirect = 1'b0;
    settle();
    check("rd2_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    check("rd2_req", {31'd0, inst_req}, 32'd1);
    check("rd2_new_addr", inst_addr, 32'h1c00_0200);
    fetch(0, 1, 32'h3333_0200, a, pv);
    check("rd2_fetch_valid", {31'd0, fs_to_ds_valid}, 32'd1);
    check("rd2_fetch_pc", fs_pc, 32'h1c00_0200);
    check("rd2_fetch_inst", fs_inst, 32'h3333_0200);

    // Redirect coinciding with the address handshake of 0x1c00_0008.
    redirect = 1'b1; redirect_pc = 32'h1c00_0008;
    tick();
    redirect = 1'b0;
    settle();
    check("rd3_pre_req", {31'd0, inst_req}, 32'd1);
    check("rd3_pre_addr", inst_addr, 32'h1c00_0008);
    inst_addr_ok = 1'b1; redirect = 1'b1; redirect_pc = 32'h1c00_0300;
    tick();
    inst_addr_ok = 1'b0; redirect = 1'b0;
    settle();
    check("rd3_req_low", {31'd0, inst_req}, 32'd0);
    check("rd3_pc", inst_addr, 32'h1c00_0300);
    tick();
    tick();
    settle();
    check("rd3_wait_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    inst_data_ok = 1'b1; inst_rdata = 32'hbad0_0008;
    tick();
    inst_data_ok = 1'b0;
    settle();
    check("rd3_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    check("rd3_req", {31'd0, inst_req}, 32'd1);
    check("rd3_new_addr", inst_addr, 32'h1c00_0300);
    fetch(1, 3, 32'h4444_0300, a, pv);
    check("rd3_fetch_pc", fs_pc, 32'h1c00_0300);
    check("rd3_fetch_inst", fs_inst, 32'h4444_0300);

    // PC wraps modulo 2^32.
    redirect = 1'b1; redirect_pc = 32'hffff_fffc;
    tick();
    redirect = 1'b0;
    fetch(0, 1, 32'h5555_fffc, a, pv);
    check("wrap_addr", a, 32'hffff_fffc);
    check("wrap_pc", fs_pc, 32'hffff_fffc);
    check("wrap_next_req", {31'd0, inst_req}, 32'd1);
    check("wrap_next_addr", inst_addr, 32'h0000_0000);

    // Reset with a request in flight.
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    reset = 1'b1;
    settle();
    check("mid_rst_req", {31'd0, inst_req}, 32'd0);
    tick();
    settle();
    check("mid_rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    reset = 1'b0;
    settle();
    check("mid_rst_req_after", {31'd0, inst_req}, 32'd1);
    check("mid_rst_addr", inst_addr, 32'h1c00_0000);

    // Random bridge delays, decode stalls and redirects against a sequential PC model.
    exp_pc = 32'h1c00_0000;
    busy = 1'b0; acnt = 0; dcnt = 0; paddr = 32'd0; accepted = 0; cyc = 0;
    while (accepted < 3000 && cyc < 80000) begin
      ds_allowin   = ($urandom_range(3) != 0);
      redirect     = (cyc > 0) && ($urandom_range(63) == 0);
      redirect_pc  = redirect ? ($urandom() & 32'hffff_fffc) : 32'd0;
      inst_addr_ok = !busy && (acnt == 0);
      inst_data_ok = busy && (dcnt == 0);
      inst_rdata   = inst_data_ok ? (paddr ^ 32'h5a5a_a5a5) : 32'd0;
      settle();
      if (fs_to_ds_valid && ds_allowin) begin
        check("rand_pc", fs_pc, exp_pc);
        check("rand_inst", fs_inst, exp_pc ^ 32'h5a5a_a5a5);
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      if (redirect) exp_pc = redirect_pc;
      if (inst_data_ok) busy = 1'b0;
      else if (busy) dcnt--;
      if (inst_req && inst_addr_ok) begin
        busy  = 1'b1;
        paddr = inst_addr;
        dcnt  = $urandom_range(6);
        acnt  = $urandom_range(7);
      end else if (!busy && acnt > 0) begin
        acnt--;
      end
      tick();
      cyc++;
    end
    redirect = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    check("rand_accepted", accepted, 32'd3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
